// File: rtl/ifu_pkg.sv
// Shared encode definitions for the fetch unit and the control decoder.
// The next-PC codes here are the single source of truth for both sides.
package ifu_pkg;

  localparam int NPC_OP_W = 2;

  typedef enum logic [NPC_OP_W-1:0] {
    NPC_PLUS4  = 2'b00,
    NPC_BRANCH = 2'b01,
    NPC_JUMP   = 2'b10,
    NPC_JR     = 2'b11
  } npc_op_e;

  // Sign-extended word offset of a branch, already scaled to bytes.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/ifu_npc.sv
// Combinational next-PC selection and misaligned-JR detection.
module ifu_npc
  import ifu_pkg::*;
(
  input  logic [31:0]         pc,
  input  logic [31:0]         instr,
  input  logic [NPC_OP_W-1:0] npc_op,
  input  logic [31:0]         jr_target,
  output logic [31:0]         npc,
  output logic                misaligned
);

  logic [31:0] seq_pc;

  assign seq_pc = pc + 32'd4;

  always_comb begin
    npc        = seq_pc;
    misaligned = 1'b0;
    case (npc_op_e'(npc_op))
      NPC_PLUS4:  npc = seq_pc;
      NPC_BRANCH: npc = seq_pc + branch_offset(instr[15:0]);
      NPC_JUMP:   npc = {seq_pc[31:28], instr[25:0], 2'b00};
      NPC_JR: begin
        npc        = jr_target;
        misaligned = (jr_target[1:0] != 2'b00);
      end
      default:    npc = seq_pc;
    endcase
  end

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: owns the PC, fetches over a req/ack handshake and
// holds the instruction until the datapath reports completion.
module ifu
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NPC_OP_W-1:0] npc_op,
  input  logic                ex_done,
  input  logic [31:0]         jr_target,
  output logic                imem_req,
  output logic [31:0]         imem_addr,
  input  logic [31:0]         imem_rdata,
  input  logic                imem_ack,
  output logic [31:0]         instr,
  output logic                instr_valid,
  output logic [31:0]         pc,
  output logic [31:0]         pc_plus4,
  output logic                fault
);

  typedef enum logic [1:0] {
    S_FETCH = 2'b00,
    S_EXEC  = 2'b01,
    S_FAULT = 2'b10
  } state_e;

  state_e      state, state_nxt;
  logic [31:0] npc;
  logic        misaligned;
  logic        fetch_done;
  logic        exec_done;

  ifu_npc u_npc (
    .pc         (pc),
    .instr      (instr),
    .npc_op     (npc_op),
    .jr_target  (jr_target),
    .npc        (npc),
    .misaligned (misaligned)
  );

  assign fetch_done = (state == S_FETCH) && imem_ack;
  assign exec_done  = (state == S_EXEC) && ex_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_FETCH;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH: if (imem_ack) state_nxt = S_EXEC;
      S_EXEC:  if (ex_done)  state_nxt = misaligned ? S_FAULT : S_FETCH;
      S_FAULT: state_nxt = S_FAULT;
      default: state_nxt = S_FETCH;
    endcase
  end

  // A misaligned JR leaves the PC untouched so the faulting PC stays visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc    <= RESET_PC;
      instr <= 32'h0;
    end else begin
      if (fetch_done)              instr <= imem_rdata;
      if (exec_done && !misaligned) pc   <= npc;
    end
  end

  assign imem_req    = (state == S_FETCH);
  assign instr_valid = (state == S_EXEC);
  assign fault       = (state == S_FAULT);
  assign imem_addr   = pc;
  assign pc_plus4    = pc + 32'd4;

endmodule

// File: tb/tb_ifu.sv
// Self-checking bench for ifu: directed scenarios plus randomized traffic
// compared against a behavioural model of fetch/execute/fault.
module tb_ifu;
  import ifu_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  npc_op;
  logic        ex_done;
  logic [31:0] jr_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ack;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fault;

  int checks   = 0;
  int failures = 0;

  // Behavioural model: which phase the unit is in, plus architectural values.
  bit          m_executing;
  bit          m_faulted;
  logic [31:0] m_pc;
  logic [31:0] m_instr;

  always #5 clk = ~clk;

  ifu #(.RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .rst         (rst),
    .npc_op      (npc_op),
    .ex_done     (ex_done),
    .jr_target   (jr_target),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_ack    (imem_ack),
    .instr       (instr),
    .instr_valid (instr_valid),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .fault       (fault)
  );

  function automatic logic [31:0] refNextPc(input logic [1:0] op, input logic [31:0] cur,
                                            input logic [31:0] ins, input logic [31:0] jr);
    logic [31:0] seq;
    logic [31:0] off;
    seq = cur + 32'd4;
    off = {{16{ins[15]}}, ins[15:0]};
    if (op == 2'd0) return seq;
    if (op == 2'd1) return seq + off * 32'd4;
    if (op == 2'd2) return {seq[31:28], ins[25:0], 2'b00};
    return jr;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    chk("imem_req",    {31'd0, imem_req},    {31'd0, !m_executing && !m_faulted});
    chk("instr_valid", {31'd0, instr_valid}, {31'd0, m_executing && !m_faulted});
    chk("fault",       {31'd0, fault},       {31'd0, m_faulted});
    chk("pc",          pc,                   m_pc);
    chk("imem_addr",   imem_addr,            m_pc);
    chk("pc_plus4",    pc_plus4,             m_pc + 32'd4);
    chk("instr",       instr,                m_instr);
  endtask

  // One clock with the given inputs; pulses are cleared right after the edge.
  task automatic applyStimulus(input logic [1:0] op, input logic done, input logic [31:0] jr,
                               input logic [31:0] rdata, input logic ack);
    npc_op     = op;
    ex_done    = done;
    jr_target  = jr;
    imem_rdata = rdata;
    imem_ack   = ack;
    @(posedge clk);
    #1;
    if (!m_faulted) begin
      if (!m_executing) begin
        if (ack) begin
          m_instr     = rdata;
          m_executing = 1'b1;
        end
      end else if (done) begin
        if (op == 2'd3 && jr[1:0] != 2'b00) m_faulted = 1'b1;
        else m_pc = refNextPc(op, m_pc, m_instr, jr);
        m_executing = 1'b0;
      end
    end
    ex_done  = 1'b0;
    imem_ack = 1'b0;
    checkOutput();
  endtask

  task automatic doReset();
    #2 rst = 1'b1;
    m_executing = 1'b0;
    m_faulted   = 1'b0;
    m_pc        = RESET_PC;
    m_instr     = 32'h0;
    ex_done     = 1'b0;
    imem_ack    = 1'b0;
    #1;
    checkOutput();
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput();
  endtask

  // Wait cycles in FETCH carry stray ex_done pulses that must be ignored.
  task automatic fetchInstr(input logic [31:0] word, input int waits);
    for (int i = 0; i < waits; i++)
      applyStimulus(2'($urandom), 1'($urandom), $urandom, $urandom, 1'b0);
    applyStimulus(2'($urandom), 1'b0, $urandom, word, 1'b1);
  endtask

  // Wait cycles in EXEC carry stray acks; the completing cycle may carry one too.
  task automatic execInstr(input logic [1:0] op, input logic [31:0] jr, input int waits);
    for (int i = 0; i < waits; i++)
      applyStimulus(2'($urandom), 1'b0, $urandom, $urandom, 1'($urandom));
    applyStimulus(op, 1'b1, jr, $urandom, 1'($urandom));
  endtask

  task automatic jumpTo(input logic [31:0] target);
    fetchInstr(32'h0000_0008, 0);
    execInstr(2'd3, target, 0);
  endtask

  initial begin
    logic [31:0] held;
    logic [1:0]  op;
    logic [31:0] jr;
    rst        = 1'b0;
    npc_op     = 2'd0;
    ex_done    = 1'b0;
    jr_target  = 32'h0;
    imem_rdata = 32'h0;
    imem_ack   = 1'b0;

    doReset();
    fetchInstr(32'h1234_5678, 1);
    execInstr(2'd0, 32'h0, 1);
    applyStimulus(2'd0, 1'b0, 32'h0, 32'h0, 1'b0);
    doReset();

    // First fetch after reset: ack after three wait cycles
    chk("first_addr", imem_addr, 32'h0);
    fetchInstr(32'h2008_0005, 3);
    chk("first_instr", instr, 32'h2008_0005);
    chk("first_valid", {31'd0, instr_valid}, 32'd1);

    execInstr(2'd3, 32'h0000_0010, 0);
    fetchInstr(32'h0000_0000, 0);
    execInstr(2'd0, 32'h0, 2);
    chk("seq_addr", imem_addr, 32'h0000_0014);

    jumpTo(32'h0000_0020);
    fetchInstr(32'h1000_FFFE, 1);
    execInstr(2'd1, 32'h0, 0);
    chk("branch_back", imem_addr, 32'h0000_001C);

    jumpTo(32'h0000_0020);
    fetchInstr(32'h1000_0003, 0);
    execInstr(2'd1, 32'h0, 1);
    chk("branch_fwd", imem_addr, 32'h0000_0030);

    jumpTo(32'h4000_0100);
    fetchInstr(32'h0800_0040, 2);
    execInstr(2'd2, 32'h0, 0);
    chk("jump", imem_addr, 32'h4000_0100);

    fetchInstr(32'h03E0_0008, 0);
    execInstr(2'd3, 32'h0000_3000, 0);
    chk("jr", imem_addr, 32'h0000_3000);

    jumpTo(32'hFFFF_FFFC);
    fetchInstr(32'h0, 0);
    execInstr(2'd0, 32'h0, 0);
    chk("wrap", imem_addr, 32'h0000_0000);

    // Stray ack while executing must not disturb the held word
    fetchInstr(32'hCAFE_0001, 0);
    held = instr;
    applyStimulus(2'd0, 1'b0, 32'h0, 32'hDEAD_BEEF, 1'b1);
    chk("spurious_ack", instr, held);
    execInstr(2'd0, 32'h0, 0);

    // Stray ex_done while fetching must not move the PC
    held = pc;
    applyStimulus(2'd2, 1'b1, 32'h0, 32'h0, 1'b0);
    chk("spurious_done", pc, held);

    for (int n = 0; n < 60; n++) begin
      fetchInstr($urandom, $urandom_range(0, 3));
      op = 2'($urandom);
      jr = $urandom & 32'hFFFF_FFFC;
      execInstr(op, jr, $urandom_range(0, 3));
    end

    // Misaligned JR: fault is sticky until reset
    jumpTo(32'h0000_0200);
    fetchInstr(32'h0320_0008, 0);
    execInstr(2'd3, 32'h0000_3002, 0);
    chk("fault_set", {31'd0, fault}, 32'd1);
    chk("fault_req", {31'd0, imem_req}, 32'd0);
    chk("fault_valid", {31'd0, instr_valid}, 32'd0);
    chk("fault_pc", pc, 32'h0000_0200);
    for (int i = 0; i < 10; i++)
      applyStimulus(2'($urandom), 1'b1, $urandom & 32'hFFFF_FFFC, $urandom, 1'b1);
    chk("fault_sticky", {31'd0, fault}, 32'd1);

    doReset();
    chk("reset_clears_fault", {31'd0, fault}, 32'd0);
    fetchInstr(32'h2008_0005, 0);
    execInstr(2'd0, 32'h0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
